// File: rtl/lcd_cmd_responder_if.sv
// lcd_cmd_responder_if: 8-bit HD44780-style parallel LCD bus.
//   LcdE       enable strobe (initiator -> display, asynchronous to the display clock)
//   LcdRS      0 = instruction register, 1 = data register
//   LcdRW      0 = write, 1 = read
//   LcdDataIn  DB7..DB0 driven by the initiator
//   LcdDataOut read data returned by the display
//   LcdDataOe  display drives LcdDataOut while high
// Modports: master = controller side, slave = display side.
`timescale 1ns/1ps
interface lcd_cmd_responder_if;
    logic       LcdE;
    logic       LcdRS;
    logic       LcdRW;
    logic [7:0] LcdDataIn;
    logic [7:0] LcdDataOut;
    logic       LcdDataOe;

    modport master (output LcdE, LcdRS, LcdRW, LcdDataIn, input LcdDataOut, LcdDataOe);
    modport slave  (input LcdE, LcdRS, LcdRW, LcdDataIn, output LcdDataOut, LcdDataOe);
endinterface

// File: rtl/lcd_cmd_responder.sv
// lcd_cmd_responder: display end of an HD44780-style 8-bit LCD bus.
// Decodes instructions/data writes on the falling edge of the synchronized
// E strobe, models the busy flag, keeps display mode flags and a 2x16
// character buffer, and answers busy-flag/address and data reads.
// Ports:
//   Clock, Reset        system clock, asynchronous active-high reset
//   bus (slave)         LcdE/LcdRS/LcdRW/LcdDataIn in, LcdDataOut/LcdDataOe out
//   Busy                busy flag
//   DisplayOn/CursorOn/BlinkOn, IncMode/ShiftMode, Func8bit/TwoLine  mode flags
//   DdramAddr           address counter
//   CharRdAddr/CharRdData  host-side combinational buffer read port
//   WrIgnored           one-cycle pulse when a write is rejected
// Build option: define LCD_STRICT_BUSY_EN to drop writes that arrive while
// Busy=1; otherwise such writes execute and reload the busy counter.
`timescale 1ns/1ps
module lcd_cmd_responder #(
    parameter int BUSY_SHORT_CYC = 1950,
    parameter int BUSY_LONG_CYC  = 76500,
    parameter int CNT_W          = 17
) (
    input  logic                    Clock,
    input  logic                    Reset,
    lcd_cmd_responder_if.slave      bus,
    output logic                    Busy,
    output logic                    DisplayOn,
    output logic                    CursorOn,
    output logic                    BlinkOn,
    output logic                    IncMode,
    output logic                    ShiftMode,
    output logic                    Func8bit,
    output logic                    TwoLine,
    output logic [6:0]              DdramAddr,
    input  logic [4:0]              CharRdAddr,
    output logic [7:0]              CharRdData,
    output logic                    WrIgnored
);
    // Counter holds the busy cycles still to come, so EXEC loads N-1.
    localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(BUSY_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(BUSY_LONG_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_BUSY} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic             e_s1, e_s2, e_d;
    logic             rs_s1, rs_s2, rw_s1, rw_s2;
    logic [7:0]       db_s1, db_s2;
    logic             cap_rs, cap_rw;
    logic [7:0]       cap_db;
    logic             pend, cmd_rs;
    logic [7:0]       cmd_db;
    logic             clr_active;
    logic [4:0]       clr_idx;
    logic [7:0]       char_mem [32];
    logic             fall, wr_fall, wr_accept, rd_step;
    logic             is_clear, is_long, can_exec;
    logic             map_ok;
    logic [4:0]       map_idx;

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc,
                                             input logic two);
        if (two) begin
            if (inc) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            else     return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end
        if (inc) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h4F : a - 7'd1;
    endfunction

    // E is synchronized; RS/RW/DB go through the same depth so they stay
    // aligned with it, and the last values seen while E was high are kept.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            {e_s1, e_s2, e_d, rs_s1, rs_s2, rw_s1, rw_s2} <= '0;
            {db_s1, db_s2, cap_db} <= '0;
            {cap_rs, cap_rw} <= '0;
        end else begin
            e_s1  <= bus.LcdE;      e_s2  <= e_s1;  e_d <= e_s2;
            rs_s1 <= bus.LcdRS;     rs_s2 <= rs_s1;
            rw_s1 <= bus.LcdRW;     rw_s2 <= rw_s1;
            db_s1 <= bus.LcdDataIn; db_s2 <= db_s1;
            if (e_s2) begin
                cap_rs <= rs_s2;
                cap_rw <= rw_s2;
                cap_db <= db_s2;
            end
        end
    end

    assign fall     = e_d & ~e_s2;
    assign wr_fall  = fall & ~cap_rw;
    assign rd_step  = fall & cap_rw & cap_rs;
    assign Busy     = (state != S_IDLE);
    assign is_clear = ~cmd_rs & (cmd_db == 8'h01);
    assign is_long  = ~cmd_rs & (cmd_db[7:2] == 6'd0) & (cmd_db[1:0] != 2'd0);
    // A pending non-clear write waits for a running clear fill to finish.
    assign can_exec = pend & (~clr_active | is_clear);

`ifdef LCD_STRICT_BUSY_EN
    logic wr_ign;
    assign wr_accept = wr_fall & ~Busy;
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) wr_ign <= 1'b0;
        else       wr_ign <= wr_fall & Busy;
    end
    assign WrIgnored = wr_ign;
`else
    assign wr_accept = wr_fall;
    assign WrIgnored = 1'b0;
`endif

    always_comb begin
        map_ok  = 1'b0;
        map_idx = 5'd0;
        if (DdramAddr[6:4] == 3'b000) begin
            map_ok  = 1'b1;
            map_idx = {1'b0, DdramAddr[3:0]};
        end else if (DdramAddr[6:4] == 3'b100) begin
            map_ok  = 1'b1;
            map_idx = {1'b1, DdramAddr[3:0]};
        end
    end

    assign bus.LcdDataOe  = e_s2 & rw_s2;
    assign bus.LcdDataOut = !bus.LcdDataOe ? 8'h00 :
                            !rs_s2         ? {Busy, DdramAddr} :
                            map_ok         ? char_mem[map_idx] : 8'h00;
    assign CharRdData     = char_mem[CharRdAddr];

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (can_exec) state_nx = S_EXEC;
            S_EXEC:  state_nx = S_BUSY;
            S_BUSY:  if (can_exec)                 state_nx = S_EXEC;
                     else if (cnt <= CNT_W'(1))    state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt        <= '0;
            pend       <= 1'b0;
            cmd_rs     <= 1'b0;
            cmd_db     <= 8'h00;
            clr_active <= 1'b0;
            clr_idx    <= 5'd0;
            {DisplayOn, CursorOn, BlinkOn, ShiftMode, TwoLine} <= '0;
            IncMode    <= 1'b1;
            Func8bit   <= 1'b1;
            DdramAddr  <= 7'h00;
            for (int i = 0; i < 32; i++) char_mem[i] <= 8'h20;
        end else begin
            if (wr_accept) begin
                pend   <= 1'b1;
                cmd_rs <= cap_rs;
                cmd_db <= cap_db;
            end else if (state_nx == S_EXEC) begin
                pend <= 1'b0;
            end

            if (state == S_EXEC)                      cnt <= is_long ? LONG_LD : SHORT_LD;
            else if (state == S_BUSY && cnt != '0)    cnt <= cnt - CNT_W'(1);

            if (state == S_EXEC) begin
                if (cmd_rs) begin
                    if (map_ok) char_mem[map_idx] <= cmd_db;
                    DdramAddr <= addr_step(DdramAddr, IncMode, TwoLine);
                end else begin
                    casez (cmd_db)
                        8'b1???????: DdramAddr <= cmd_db[6:0];
                        8'b01??????: ;
                        8'b001?????: {Func8bit, TwoLine} <= cmd_db[4:3];
                        8'b0001????: if (!cmd_db[3])
                                         DdramAddr <= addr_step(DdramAddr, cmd_db[2], TwoLine);
                        8'b00001???: {DisplayOn, CursorOn, BlinkOn} <= cmd_db[2:0];
                        8'b000001??: {IncMode, ShiftMode} <= cmd_db[1:0];
                        8'b0000001?: DdramAddr <= 7'h00;
                        8'b00000001: begin
                            DdramAddr <= 7'h00;
                            IncMode   <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end else if (rd_step) begin
                DdramAddr <= addr_step(DdramAddr, IncMode, TwoLine);
            end

            // Clear refills one entry per cycle; a new Clear restarts at 0.
            if (state == S_EXEC && is_clear) begin
                clr_active <= 1'b1;
                clr_idx    <= 5'd0;
            end else if (clr_active) begin
                char_mem[clr_idx] <= 8'h20;
                clr_idx           <= clr_idx + 5'd1;
                if (clr_idx == 5'd31) clr_active <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_lcd_cmd_responder.sv
`timescale 1ns/1ps
module tb_lcd_cmd_responder;
    localparam int SHORT = 50;
    localparam int LONG  = 120;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Busy, DisplayOn, CursorOn, BlinkOn, IncMode, ShiftMode, Func8bit, TwoLine;
    logic [6:0] DdramAddr;
    logic [4:0] CharRdAddr;
    logic [7:0] CharRdData;
    logic       WrIgnored;
    logic [6:0] flags;

    int tests = 0;
    int fails = 0;

    always #5 Clock = ~Clock;

    lcd_cmd_responder_if bus();

    lcd_cmd_responder #(.BUSY_SHORT_CYC(SHORT), .BUSY_LONG_CYC(LONG), .CNT_W(17)) dut (
        .Clock(Clock), .Reset(Reset), .bus(bus),
        .Busy(Busy), .DisplayOn(DisplayOn), .CursorOn(CursorOn), .BlinkOn(BlinkOn),
        .IncMode(IncMode), .ShiftMode(ShiftMode), .Func8bit(Func8bit), .TwoLine(TwoLine),
        .DdramAddr(DdramAddr), .CharRdAddr(CharRdAddr), .CharRdData(CharRdData),
        .WrIgnored(WrIgnored)
    );

    assign flags = {DisplayOn, CursorOn, BlinkOn, IncMode, ShiftMode, Func8bit, TwoLine};

    // Cycle stamps of Busy edges and a running count of WrIgnored cycles.
    int   cyc = 0;
    int   rise_t = 0, fall_t = 0, ign_n = 0;
    logic busy_prev = 1'b0;
    always @(posedge Clock) cyc <= cyc + 1;
    always @(negedge Clock) begin
        busy_prev <= Busy;
        if (Busy && !busy_prev) rise_t <= cyc;
        if (!Busy && busy_prev) fall_t <= cyc;
        if (WrIgnored === 1'b1) ign_n <= ign_n + 1;
    end

    // ---------------- reference model (display behaviour) ----------------
    logic [7:0] m_buf [32];
    int         m_addr;
    bit         m_d, m_c, m_b, m_i, m_s, m_f8, m_two;

    function automatic logic [6:0] m_flags();
        return {m_d, m_c, m_b, m_i, m_s, m_f8, m_two};
    endfunction

    // Address treated as a position on a ring of 80 cells.
    function automatic int mstep(int a, bit inc);
        int p;
        if (m_two) begin
            p = (a < 64) ? a : a - 24;
            p = inc ? (p + 1) % 80 : (p + 79) % 80;
            return (p < 40) ? p : p + 24;
        end
        return inc ? (a + 1) % 80 : (a + 79) % 80;
    endfunction

    function automatic int mmap(int a);
        if (a < 16) return a;
        if (a >= 64 && a < 80) return a - 48;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        m_addr = 0;
        {m_d, m_c, m_b, m_s, m_two} = '0;
        m_i = 1; m_f8 = 1;
    endtask

    task automatic model_write(input bit rs, input logic [7:0] db);
        int idx;
        if (rs) begin
            idx = mmap(m_addr);
            if (idx >= 0) m_buf[idx] = db;
            m_addr = mstep(m_addr, m_i);
        end
        else if (db[7]) m_addr = int'(db[6:0]);
        else if (db[6]) ;
        else if (db[5]) begin m_f8 = db[4]; m_two = db[3]; end
        else if (db[4]) begin if (!db[3]) m_addr = mstep(m_addr, db[2]); end
        else if (db[3]) {m_d, m_c, m_b} = db[2:0];
        else if (db[2]) begin m_i = db[1]; m_s = db[0]; end
        else if (db[1]) m_addr = 0;
        else if (db[0]) begin
            m_addr = 0; m_i = 1;
            for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
        end
    endtask

    // ---------------- bus drivers ----------------
    task automatic drive_write(input bit rs, input logic [7:0] db);
        @(negedge Clock);
        bus.LcdRS = rs; bus.LcdRW = 1'b0; bus.LcdDataIn = db; bus.LcdE = 1'b1;
        repeat (4) @(negedge Clock);
        bus.LcdE = 1'b0;
    endtask

    task automatic bus_read(input bit rs, output logic [7:0] data,
                            output logic oe_hi, output logic oe_lo);
        @(negedge Clock);
        bus.LcdRS = rs; bus.LcdRW = 1'b1; bus.LcdE = 1'b1;
        repeat (4) @(negedge Clock);
        data  = bus.LcdDataOut;
        oe_hi = bus.LcdDataOe;
        bus.LcdE = 1'b0;
        repeat (4) @(negedge Clock);
        oe_lo = bus.LcdDataOe;
        bus.LcdRW = 1'b0;
    endtask

    // Waits for one Busy high period to end; dur = its length in cycles.
    task automatic wait_idle(output int dur, input string nm);
        bit hi = 0, done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge Clock);
            if (Busy) hi = 1;
            else if (hi) done = 1;
        end
        @(negedge Clock);
        dur = fall_t - rise_t;
        if (!done) begin
            tests++; fails++;
            $display("FAIL %s: Busy cycle never completed", nm);
            dur = -1;
        end
    endtask

    task automatic do_write(input bit rs, input logic [7:0] db, input string nm, output int dur);
        drive_write(rs, db);
        model_write(rs, db);
        wait_idle(dur, nm);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [7:0] d;
        logic       oh, ol;
        Reset = 1'b1;
        bus.LcdE = 0; bus.LcdRS = 0; bus.LcdRW = 0; bus.LcdDataIn = 0; CharRdAddr = 0;
        model_reset();
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        tests++; if (flags !== 7'b0001010) begin fails++; $display("FAIL reset_flags: got %b exp %b", flags, 7'b0001010); end
        tests++; if ({Busy, WrIgnored, DdramAddr} !== 9'd0) begin fails++; $display("FAIL reset_busy_addr: got %b/%b/%h exp 0/0/00", Busy, WrIgnored, DdramAddr); end
        tests++; if ({bus.LcdDataOe, bus.LcdDataOut} !== 9'd0) begin fails++; $display("FAIL reset_dout: got oe=%b out=%h exp 0/00", bus.LcdDataOe, bus.LcdDataOut); end
        for (int i = 0; i < 32; i++) begin
            CharRdAddr = 5'(i); #1;
            tests++; if (CharRdData !== 8'h20) begin fails++; $display("FAIL reset_buf[%0d]: got %h exp 20", i, CharRdData); end
        end
        bus_read(1'b0, d, oh, ol);
        tests++; if (d !== 8'h00) begin fails++; $display("FAIL reset_bf_read: got %h exp 00", d); end
        tests++; if (oh !== 1'b1 || ol !== 1'b0) begin fails++; $display("FAIL reset_bf_oe: got hi=%b lo=%b exp 1/0", oh, ol); end
    endtask

    task automatic test_busy_short();
        int dur;
        do_write(1'b0, 8'h38, "fset38", dur);
        tests++; if (dur != SHORT) begin fails++; $display("FAIL busy_short_len: got %0d exp %0d", dur, SHORT); end
        tests++; if ({Func8bit, TwoLine} !== 2'b11) begin fails++; $display("FAIL fset_flags: got %b exp 11", {Func8bit, TwoLine}); end
    endtask

    task automatic test_sequence();
        int dur;
        do_write(1'b0, 8'h0F, "dctl", dur);
        do_write(1'b0, 8'h06, "entry", dur);
        do_write(1'b0, 8'hC5, "setaddr", dur);
        do_write(1'b1, 8'h41, "data41", dur);
        tests++; if (flags !== 7'b1111011) begin fails++; $display("FAIL seq_flags: got %b exp %b", flags, 7'b1111011); end
        CharRdAddr = 5'd21; #1;
        tests++; if (CharRdData !== 8'h41) begin fails++; $display("FAIL seq_buf21: got %h exp 41", CharRdData); end
        tests++; if (DdramAddr !== 7'h46) begin fails++; $display("FAIL seq_addr: got %h exp 46", DdramAddr); end
    endtask

    task automatic test_wrap();
        int dur;
        do_write(1'b0, 8'hA7, "set27", dur);
        do_write(1'b1, 8'h42, "data_unmapped", dur);
        tests++; if (DdramAddr !== 7'h40) begin fails++; $display("FAIL wrap_27_40: got %h exp 40", DdramAddr); end
        for (int i = 0; i < 32; i++) begin
            CharRdAddr = 5'(i); #1;
            tests++; if (CharRdData !== m_buf[i]) begin fails++; $display("FAIL wrap_drop_buf[%0d]: got %h exp %h", i, CharRdData, m_buf[i]); end
        end
        do_write(1'b0, 8'h04, "dec_mode", dur);
        do_write(1'b0, 8'h80, "set00", dur);
        do_write(1'b1, 8'h55, "data55", dur);
        tests++; if (DdramAddr !== 7'h67) begin fails++; $display("FAIL wrap_00_67: got %h exp 67", DdramAddr); end
        CharRdAddr = 5'd0; #1;
        tests++; if (CharRdData !== 8'h55) begin fails++; $display("FAIL wrap_buf0: got %h exp 55", CharRdData); end
        // one-line mode wraps over 0x00..0x4F
        do_write(1'b0, 8'h30, "oneline", dur);
        do_write(1'b0, 8'h80, "set00b", dur);
        do_write(1'b1, 8'h66, "data66", dur);
        tests++; if (DdramAddr !== 7'h4F) begin fails++; $display("FAIL wrap1_00_4F: got %h exp 4F", DdramAddr); end
        do_write(1'b0, 8'h06, "inc_mode", dur);
        do_write(1'b0, 8'hCF, "set4F", dur);
        do_write(1'b1, 8'h77, "data77", dur);
        tests++; if (DdramAddr !== 7'h00) begin fails++; $display("FAIL wrap1_4F_00: got %h exp 00", DdramAddr); end
        CharRdAddr = 5'd31; #1;
        tests++; if (CharRdData !== 8'h77) begin fails++; $display("FAIL wrap_buf31: got %h exp 77", CharRdData); end
        do_write(1'b0, 8'h38, "twoline", dur);
    endtask

    task automatic test_busy_write();
        int dur, t1, t2, ign0;
        ign0 = ign_n;
        drive_write(1'b0, 8'h08);
        model_write(1'b0, 8'h08);
        t1 = cyc;
        repeat (10) @(negedge Clock);
        drive_write(1'b0, 8'h0C);
        t2 = cyc;
        wait_idle(dur, "busy_write");
`ifdef LCD_STRICT_BUSY_EN
        tests++; if (dur != SHORT) begin fails++; $display("FAIL strict_busy_len: got %0d exp %0d", dur, SHORT); end
        tests++; if (ign_n - ign0 != 1) begin fails++; $display("FAIL strict_wrignored: got %0d exp 1", ign_n - ign0); end
        tests++; if (DisplayOn !== 1'b0) begin fails++; $display("FAIL strict_display: got %b exp 0", DisplayOn); end
`else
        model_write(1'b0, 8'h0C);
        tests++; if (dur != (t2 - t1) + SHORT) begin fails++; $display("FAIL reload_busy_len: got %0d exp %0d", dur, (t2 - t1) + SHORT); end
        tests++; if (ign_n - ign0 != 0) begin fails++; $display("FAIL wrignored_tied: got %0d exp 0", ign_n - ign0); end
        tests++; if (DisplayOn !== 1'b1) begin fails++; $display("FAIL reload_display: got %b exp 1", DisplayOn); end
`endif
        tests++; if (flags !== m_flags() || DdramAddr !== 7'(m_addr)) begin fails++; $display("FAIL busy_write_state: got %b/%h exp %b/%h", flags, DdramAddr, m_flags(), 7'(m_addr)); end
    endtask

    task automatic test_random();
        int         dur, p, r;
        logic [7:0] db, d, exp_d;
        logic       oh, ol;
        bit         rs;
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 8);
            rs = 0;
            case (r)
                0: begin rs = 1; db = 8'($urandom); end
                1: begin p = $urandom_range(0, 79); db = 8'h80 | 8'((p < 40) ? p : p + 24); end
                2: db = 8'h04 | 8'($urandom_range(0, 3));
                3: db = 8'h08 | 8'($urandom_range(0, 7));
                4: db = 8'h10 | 8'($urandom_range(0, 15));
                5: db = 8'h28 | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 7));
                8: begin p = $urandom_range(0, 3); db = (p == 0) ? 8'h00 : (p == 1) ? 8'h01 :
                                                          (p == 2) ? 8'h02 : 8'h40 | 8'($urandom_range(0, 63)); end
                default: db = 8'h00;
            endcase
            if (r == 6 || r == 7) begin
                rs = (r == 6);
                exp_d = rs ? ((mmap(m_addr) >= 0) ? m_buf[mmap(m_addr)] : 8'h00) : {1'b0, 7'(m_addr)};
                bus_read(rs, d, oh, ol);
                if (rs) m_addr = mstep(m_addr, m_i);
                tests++; if (d !== exp_d || oh !== 1'b1 || ol !== 1'b0) begin fails++; $display("FAIL rand_read%0d rs=%0d: got %h oe=%b%b exp %h oe=10", n, rs, d, oh, ol, exp_d); end
            end else begin
                do_write(rs, db, "rand_write", dur);
                p = (!rs && db[7:2] == 0 && db[1:0] != 0) ? LONG : SHORT;
                tests++; if (dur != p) begin fails++; $display("FAIL rand_busy%0d rs=%0d db=%h: got %0d exp %0d", n, rs, db, dur, p); end
            end
            tests++; if (flags !== m_flags() || DdramAddr !== 7'(m_addr)) begin fails++; $display("FAIL rand_state%0d: got %b/%h exp %b/%h", n, flags, DdramAddr, m_flags(), 7'(m_addr)); end
            for (int i = 0; i < 32; i++) begin
                CharRdAddr = 5'(i); #1;
                tests++; if (CharRdData !== m_buf[i]) begin fails++; $display("FAIL rand_buf%0d[%0d]: got %h exp %h", n, i, CharRdData, m_buf[i]); end
            end
        end
    endtask

    task automatic test_clear();
        int dur;
        do_write(1'b0, 8'h06, "entry", dur);
        do_write(1'b0, 8'h80, "line1", dur);
        for (int i = 0; i < 16; i++) do_write(1'b1, 8'(8'h61 + i), "fill1", dur);
        do_write(1'b0, 8'hC0, "line2", dur);
        for (int i = 0; i < 16; i++) do_write(1'b1, 8'(8'h41 + i), "fill2", dur);
        do_write(1'b0, 8'h01, "clear", dur);
        tests++; if (dur != LONG) begin fails++; $display("FAIL clear_busy_len: got %0d exp %0d", dur, LONG); end
        tests++; if (DdramAddr !== 7'h00 || IncMode !== 1'b1) begin fails++; $display("FAIL clear_addr_inc: got %h/%b exp 00/1", DdramAddr, IncMode); end
        for (int i = 0; i < 32; i++) begin
            CharRdAddr = 5'(i); #1;
            tests++; if (CharRdData !== 8'h20) begin fails++; $display("FAIL clear_buf[%0d]: got %h exp 20", i, CharRdData); end
        end
        // reset in the middle of a clear fill
        do_write(1'b0, 8'h0F, "dctl", dur);
        do_write(1'b0, 8'hCF, "set4F", dur);
        do_write(1'b1, 8'hA5, "dataA5", dur);
        drive_write(1'b0, 8'h01);
        repeat (10) @(negedge Clock);
        tests++; if (Busy !== 1'b1) begin fails++; $display("FAIL midclear_busy: got %b exp 1", Busy); end
        Reset = 1'b1;
        #1;
        tests++; if (flags !== 7'b0001010 || Busy !== 1'b0 || DdramAddr !== 7'h00) begin fails++; $display("FAIL midclear_reset: got %b/%b/%h exp 0001010/0/00", flags, Busy, DdramAddr); end
        for (int i = 0; i < 32; i++) begin
            CharRdAddr = 5'(i); #1;
            tests++; if (CharRdData !== 8'h20) begin fails++; $display("FAIL midclear_buf[%0d]: got %h exp 20", i, CharRdData); end
        end
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_busy_short();
        test_sequence();
        test_wrap();
        test_busy_write();
        test_random();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lcd_cmd_responder.md
Name: lcd_cmd_responder

Overview:
- Synthesizable HD44780-style LCD responder: the display end of the 8-bit parallel bus driven by the team's LCD init/write controllers.
- Samples E/RS/RW/DB and decodes instructions and data writes.
- Models the busy flag and timing, holds display mode flags and a 2x16 character buffer.
- Answers busy-flag/address and data reads.
- Serves as an on-chip loopback target and bench responder for the controllers.

Parameters:
BUSY_SHORT_CYC, 1950, Clock cycles busy after normal instructions/data (39 us at 50 MHz).
BUSY_LONG_CYC, 76500, Clock cycles busy after Clear/Return Home (1.53 ms); must be >= 40.
CNT_W, 17, busy counter width; must hold BUSY_LONG_CYC.

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-high reset
LcdE  in  1  bus enable strobe (asynchronous to Clock)
LcdRS  in  1  0=instruction, 1=data
LcdRW  in  1  0=write, 1=read
LcdDataIn  in  8  DB7..DB0 from initiator
LcdDataOut  out  8  read data to initiator
LcdDataOe  out  1  drive enable for LcdDataOut
Busy  out  1  busy flag
DisplayOn / CursorOn / BlinkOn  out  1 each  display control bits D/C/B
IncMode / ShiftMode  out  1 each  entry mode I/D and S
Func8bit / TwoLine  out  1 each  function set DL and N
DdramAddr  out  7  address counter
CharRdAddr  in  5  host-side buffer read index (0-15 line 1, 16-31 line 2)
CharRdData  out  8  buffer[CharRdAddr], combinational
WrIgnored  out  1  one-cycle pulse: write rejected (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0 except Func8bit=1 and IncMode=1.
  - DdramAddr=0, LcdDataOut=0, LcdDataOe=0.
  - Buffer all 8'h20; FSM in IDLE.
- Input sampling:
  - LcdE passes through a 2-flop synchronizer.
  - RS/RW/DB are registered in parallel with it.
  - A transaction is executed on the synchronized E falling edge (1->0), using the RS/RW/DB values captured on the last cycle E was high.
  - E high and low time must each be >= 3 Clock cycles.
- Reads (RW=1):
  - LcdDataOe=1 while synced E=1 and RW=1; otherwise 0.
  - RS=0: LcdDataOut = {Busy, DdramAddr}. Permitted while busy. No side effects.
  - RS=1: LcdDataOut = buffer byte at DdramAddr (8'h00 if unmapped). On the falling edge, the address steps per IncMode. Does not set Busy.
- Writes (RW=0), FSM IDLE -> EXEC (1 cycle) -> BUSY -> IDLE:
  - The counter loads BUSY_SHORT_CYC or BUSY_LONG_CYC in EXEC.
  - Busy=1 from the EXEC cycle until the counter reaches 0.
  - Busy falls exactly N cycles after EXEC.
- Instruction decode (RS=0, highest set bit wins):
  - DB7 Set DDRAM: DdramAddr=DB[6:0]. Short busy.
  - DB6 Set CGRAM: no effect. Short busy.
  - DB5 Function set: Func8bit=DB4, TwoLine=DB3. Short busy.
  - DB4 Cursor/shift: S/C=0 steps the address (R/L=1 inc, 0 dec); S/C=1 no effect. Short busy.
  - DB3 Display control: DisplayOn=DB2, CursorOn=DB1, BlinkOn=DB0. Short busy.
  - DB2 Entry mode: IncMode=DB1, ShiftMode=DB0. Short busy.
  - DB1 Return home: DdramAddr=0. Long busy.
  - DB0 Clear: DdramAddr=0, IncMode=1. Buffer refilled with 8'h20, one entry per cycle during BUSY (32 cycles). Long busy.
  - 8'h00: no effect. Short busy.
- Data write (RS=1):
  - Store DB at the mapped index, then step the address.
  - Short busy.
- Address map:
  - Addresses 0x00-0x0F -> index 0-15.
  - Addresses 0x40-0x4F -> index 16-31.
  - Other addresses are unmapped: writes are dropped, but the address still steps.
- Address step, TwoLine=1:
  - Increment: 0x27 -> 0x40, 0x67 -> 0x00.
  - Decrement: 0x00 -> 0x67, 0x40 -> 0x27.
- Address step, TwoLine=0:
  - Increment: 0x4F -> 0x00.
  - Decrement: 0x00 -> 0x4F.
- Reset mid-transaction or mid-clear: everything returns to reset values immediately, including the buffer.

Optional Feature:
LCD_STRICT_BUSY_EN
- Defined: a write whose falling edge arrives while Busy=1 is dropped. State, address and counter are unchanged; WrIgnored pulses for 1 cycle.
- Undefined: the write executes immediately, and the busy counter reloads from the new instruction's value. An in-progress clear fill restarts from index 0 only if the new write is also Clear; otherwise the fill finishes before the new write is applied. WrIgnored is tied 0.

Test Plan:
- Reset, then read BF (RS=0,RW=1) -> LcdDataOut=8'h00, Oe=1 only while E high; Func8bit=1, IncMode=1, CharRdData=8'h20 for all 32 indices.
- Write 8'h38, poll BF -> Busy=1 for exactly BUSY_SHORT_CYC cycles; Func8bit=1, TwoLine=1.
- Write 8'h0F, 8'h06, 8'hC5, then data 8'h41 -> DisplayOn/CursorOn/BlinkOn=1, IncMode=1, buffer[21]=8'h41, DdramAddr=0x46.
- Set address 8'hA7 (0x27), write data 8'h42 with TwoLine=1 -> write dropped (unmapped), DdramAddr wraps to 0x40; with IncMode=0 at 0x00, one write -> 0x67.
- Fill the buffer, write 8'h01 -> Busy high for BUSY_LONG_CYC; all indices 8'h20; DdramAddr=0; assert Reset mid-clear -> immediate reset values.
- With LCD_STRICT_BUSY_EN: write 8'h0C while busy -> WrIgnored pulse, DisplayOn unchanged. Without it: DisplayOn=1 and the busy counter reloads.
